// File: rtl/input_holder_pkg.sv
// Shared cipher datapath types: holder/interface state encodings and the default byte width.
package input_holder_pkg;

  localparam int unsigned CipherWidth = 8;

  typedef enum logic [1:0] {
    InEmpty,
    InHolding,
    InFull
  } input_holder_state_t;

  typedef enum logic [1:0] {
    OutEmpty,
    OutHolding,
    OutFull
  } output_holder_state_t;

  typedef enum logic [1:0] {
    IfIdle,
    IfLoad,
    IfRun,
    IfDrain
  } interface_state_t;

endpackage

// File: rtl/input_holder_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is always visible on head.
module input_holder_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0) && !flush;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/input_holder.sv
// Capture side of the cipher datapath: edge-detects user writes, buffers bytes, issues them
// one per pulse to the cipher. Define INPUT_HOLDER_SYNC_EN to 2-flop synchronize the pins.
module input_holder
  import input_holder_pkg::*;
#(
  parameter int unsigned WIDTH = CipherWidth,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    pin_data,
  input  logic                pin_wr_strobe,
  input  logic                cipher_ready,
  input  logic                flush,
  output logic [WIDTH-1:0]    data_out,
  output logic                data_out_pulse,
  output input_holder_state_t input_holder_state_out,
  output logic                overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             strobe_s;
  logic [WIDTH-1:0] data_s;

`ifdef INPUT_HOLDER_SYNC_EN
  logic             strobe_s1_q, strobe_s2_q;
  logic [WIDTH-1:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_s1_q <= 1'b0;
      strobe_s2_q <= 1'b0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
    end else begin
      strobe_s1_q <= pin_wr_strobe;
      strobe_s2_q <= strobe_s1_q;
      data_s1_q   <= pin_data;
      data_s2_q   <= data_s1_q;
    end
  end

  assign strobe_s = strobe_s2_q;
  assign data_s   = data_s2_q;
`else
  assign strobe_s = pin_wr_strobe;
  assign data_s   = pin_data;
`endif

  logic             strobe_prev_q;
  logic             pulse_q, pulse_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             push, pop, full;

  assign push = strobe_s && !strobe_prev_q;
  // The idle cycle after every pulse comes from gating the next pop on the current pulse.
  assign pop  = (count != '0) && cipher_ready && !pulse_q;
  assign full = (count == CW'(DEPTH));

  input_holder_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(data_s),
    .head (head),
    .count(count)
  );

  always_comb begin
    pulse_d    = 1'b0;
    overflow_d = overflow_q;
    data_out_d = data_out_q;
    if (flush) begin
      overflow_d = 1'b0;
    end else begin
      pulse_d = pop;
      if (pop) data_out_d = head;
      if (push && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
      overflow_q    <= 1'b0;
      data_out_q    <= '0;
    end else begin
      strobe_prev_q <= strobe_s;
      pulse_q       <= pulse_d;
      overflow_q    <= overflow_d;
      data_out_q    <= data_out_d;
    end
  end

  always_comb begin
    input_holder_state_out = InHolding;
    if (count == '0)  input_holder_state_out = InEmpty;
    else if (full)    input_holder_state_out = InFull;
  end

  assign data_out       = data_out_q;
  assign data_out_pulse = pulse_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_input_holder.sv
// Self-checking bench for input_holder: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_input_holder;
  import input_holder_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
`ifdef INPUT_HOLDER_SYNC_EN
  localparam int ExpLatency = 4;
`else
  localparam int ExpLatency = 2;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [W-1:0]        pin_data = '0;
  logic                pin_wr_strobe = 1'b0;
  logic                cipher_ready = 1'b0;
  logic                flush = 1'b0;
  logic [W-1:0]        data_out;
  logic                data_out_pulse;
  input_holder_state_t st;
  logic                overflow;

  always #5 clk = ~clk;

  input_holder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pin_data              (pin_data),
    .pin_wr_strobe         (pin_wr_strobe),
    .cipher_ready          (cipher_ready),
    .flush                 (flush),
    .data_out              (data_out),
    .data_out_pulse        (data_out_pulse),
    .input_holder_state_out(st),
    .overflow              (overflow)
  );

  // Reference model state
  logic [W-1:0] mq[$];
  logic         m_prev, m_pulse, m_ovf;
  logic [W-1:0] m_dout;
  logic         m_s1, m_s2;
  logic [W-1:0] m_d1, m_d2;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] issued[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic input_holder_state_t exp_state();
    if (mq.size() == 0) return InEmpty;
    if (mq.size() == D) return InFull;
    return InHolding;
  endfunction

  task automatic model_edge(input logic s, input logic [W-1:0] d, input logic rdy,
                            input logic fl, input logic r);
    logic         se, push, pop, was_full;
    logic [W-1:0] de;
    if (r) begin
      mq.delete();
      m_prev = 0; m_pulse = 0; m_ovf = 0; m_dout = '0;
      m_s1 = 0; m_s2 = 0; m_d1 = '0; m_d2 = '0;
      return;
    end
`ifdef INPUT_HOLDER_SYNC_EN
    se = m_s2; de = m_d2;
    m_s2 = m_s1; m_d2 = m_d1;
    m_s1 = s; m_d1 = d;
`else
    se = s; de = d;
`endif
    push = se && !m_prev;
    m_prev = se;
    if (fl) begin
      mq.delete();
      m_ovf = 0;
      m_pulse = 0;
    end else begin
      pop = (mq.size() > 0) && rdy && !m_pulse;
      was_full = (mq.size() == D);
      if (pop) m_dout = mq.pop_front();
      if (push) begin
        if (was_full && !pop) m_ovf = 1;
        else mq.push_back(de);
      end
      m_pulse = pop;
    end
  endtask

  task automatic cycle(input logic s, input logic [W-1:0] d, input logic rdy,
                       input logic fl, input logic r);
    pin_wr_strobe = s; pin_data = d; cipher_ready = rdy; flush = fl; rst = r;
    @(posedge clk);
    model_edge(s, d, rdy, fl, r);
    #1;
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("pulse", 32'(data_out_pulse), 32'(m_pulse));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("state", 32'(st), 32'(exp_state()));
    if (data_out_pulse) issued.push_back(data_out);
  endtask

  task automatic write(input logic [W-1:0] b, input logic rdy);
    cycle(1, b, rdy, 0, 0);
    cycle(1, b, rdy, 0, 0);
    cycle(0, b, rdy, 0, 0);
    cycle(0, b, rdy, 0, 0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, rdy, 0, 0);
  endtask

  task automatic chk_issued(input string tag, input logic [4*W-1:0] exp, input int n);
    chk({tag, "_count"}, 32'(issued.size()), 32'(n));
    for (int i = 0; i < n && i < issued.size(); i++)
      chk(tag, 32'(issued[i]), 32'(exp[(n-1-i)*W +: W]));
  endtask

  initial begin
    int lat;
    logic s_lvl;
    int hold;

    // Reset, then a long strobe gives exactly one write
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_state", 32'(st), 32'(InEmpty));
    idle(2, 1);
    issued.delete();
    for (int i = 0; i < 10; i++) cycle(1, 8'hA5, 1, 0, 0);
    idle(6, 1);
    chk_issued("held_strobe", 32'h000000A5, 1);
    chk("held_state", 32'(st), 32'(InEmpty));

    // Fill with cipher stalled, then drain in order
    issued.delete();
    write(8'h11, 0); write(8'h22, 0); write(8'h33, 0); write(8'h44, 0);
    chk("fill_state", 32'(st), 32'(InFull));
    chk("fill_no_pulse", 32'(issued.size()), 32'd0);
    idle(10, 1);
    chk_issued("drain", 32'h11223344, 4);

    // Overflow: fifth write dropped
    issued.delete();
    write(8'h11, 0); write(8'h22, 0); write(8'h33, 0); write(8'h44, 0);
    write(8'h55, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    idle(10, 1);
    chk_issued("ovf_drain", 32'h11223344, 4);
    cycle(0, 8'h00, 0, 1, 0);
    chk("ovf_flush_clear", 32'(overflow), 32'd0);

    // Write coinciding with a pop on a full FIFO is kept
    issued.delete();
    write(8'h11, 0); write(8'h22, 0); write(8'h33, 0); write(8'h44, 0);
    write(8'h55, 1);
    idle(12, 1);
    chk("coinc_no_ovf", 32'(overflow), 32'd0);
    chk("coinc_count", 32'(issued.size()), 32'd5);
    if (issued.size() == 5) chk("coinc_last", 32'(issued[4]), 32'h55);

    // Flush discards buffered bytes
    issued.delete();
    write(8'h01, 0); write(8'h02, 0); write(8'h03, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("flush_state", 32'(st), 32'(InEmpty));
    chk("flush_pulse", 32'(data_out_pulse), 32'd0);
    idle(3, 1);
    chk("flush_no_issue", 32'(issued.size()), 32'd0);
    write(8'h66, 1);
    idle(4, 1);
    chk_issued("after_flush", 32'h00000066, 1);

    // Reset while full with a pulse in flight
    write(8'hC1, 0); write(8'hC2, 0); write(8'hC3, 0); write(8'hC4, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 1);
    chk("rst_pulse", 32'(data_out_pulse), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_state", 32'(st), 32'(InEmpty));

    // Write-to-pulse latency
    idle(3, 1);
    lat = 0;
    cycle(1, 8'h77, 1, 0, 0);
    lat = 1;
    while (!data_out_pulse && lat < 12) begin
      cycle(1, 8'h77, 1, 0, 0);
      lat++;
    end
    chk("latency", 32'(lat), 32'(ExpLatency));
    chk("latency_data", 32'(data_out), 32'h77);
    idle(4, 1);

    // Random traffic with slow strobes, stalls, occasional flush/reset
    s_lvl = 0;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        s_lvl = ~s_lvl;
        hold = $urandom_range(1, 4);
        if (s_lvl) pin_data = 8'($urandom);
      end
      hold--;
      cycle(s_lvl, pin_data, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
            $urandom_range(0, 200) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_holder.md
Name: input_holder

Overview:
- Capture side of the stream-cipher datapath, the mirror of the output-side holder.
- Accepts bytes written by the chip user on the input pins. Each write is marked by a level strobe that the user raises and lowers slowly.
- Buffers the bytes in a small FIFO. Presents them one at a time to the encryption block as a byte plus a one-cycle valid pulse, only when the cipher reports it is ready.
- Reports its fill state to the interface FSM.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pin_data  in  WIDTH  byte from chip input pins
- pin_wr_strobe  in  1  user write strobe; a write is its rising edge
- cipher_ready  in  1  encryption block can accept a byte this cycle
- flush  in  1  from interface FSM; discard all buffered bytes
- data_out  out  WIDTH  byte to encryption block
- data_out_pulse  out  1  one-cycle valid for data_out
- input_holder_state_out  out  input_holder_state_t  EMPTY / HOLDING / FULL, to interface FSM
- overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers and count = 0; data_out = 0; data_out_pulse = 0; overflow = 0; state = EMPTY.
  - Edge-detect history register = 0.
  - Reset mid-operation discards all contents and any pending pulse.
- Write detect:
  - strobe_s is the strobe after the optional synchronizer.
  - strobe_prev is strobe_s registered.
  - push = strobe_s & !strobe_prev.
  - A strobe held high produces exactly one push.
- Push:
  - pin_data is sampled in the same cycle as push and written at the tail.
  - If count==DEPTH and no pop that cycle: byte dropped, overflow<=1, contents unchanged.
  - Full with a simultaneous pop: push accepted, count unchanged.
- Pop/issue:
  - Condition: count>0 & cipher_ready & !data_out_pulse.
  - On that edge: data_out <= head entry, data_out_pulse <= 1, head pointer advances.
  - data_out_pulse is therefore high for exactly one cycle, with at least one idle cycle between pulses.
  - data_out holds its value until the next issue.
- Latency (no synchronizer, empty FIFO, cipher_ready=1): strobe first sampled high at edge E0 gives push at E0 and data_out_pulse high after E1.
- Pointers: log2(DEPTH) bits, wrap naturally. count is log2(DEPTH)+1 bits.
- Flush:
  - Highest priority after rst.
  - Clears pointers, count and overflow; suppresses any push or pop that cycle; data_out_pulse <= 0.
  - data_out retains its last value.
- State output, combinational from count:
  - EMPTY when 0.
  - FULL when DEPTH.
  - else HOLDING.

Optional Feature:
- Macro INPUT_HOLDER_SYNC_EN.
- Defined: pin_wr_strobe passes through a 2-flop synchronizer (reset to 0) before edge detect. pin_data is also 2-flop synchronized in parallel. Write latency +2 cycles.
- Undefined: strobe and data are used directly and are assumed synchronous to clk.

Decomposition:
- Shared cipher package holds input_holder_state_t (EMPTY, HOLDING, FULL), alongside interface_state_t and the output holder's state type.
- Also in the package: the WIDTH default constant, shared with the output holder.
- One sub-module, sync_fifo (WIDTH, DEPTH; push/pop/flush, count, head data); the top holds edge detect, issue logic and the synchronizer.

Test Plan:
- Reset then idle: all outputs 0, state EMPTY; strobe held high for 10 cycles with pin_data=0xA5 -> exactly one push, one data_out_pulse with data_out=0xA5, state returns to EMPTY.
- cipher_ready=0, four writes 0x11,0x22,0x33,0x44 -> state FULL, no pulses. Raise cipher_ready -> pulses in order 0x11..0x44, each one cycle, separated by one idle cycle.
- Full FIFO plus fifth write 0x55 with cipher_ready=0 -> overflow=1, then drain yields 0x11..0x44 only. Repeat with the write coinciding with a pop -> 0x55 retained, overflow stays 0.
- Three bytes buffered, assert flush -> state EMPTY, overflow cleared, no pulse. A next write of 0x66 issues 0x66.
- rst asserted while FULL with a pulse pending -> data_out_pulse 0 the following cycle, data_out=0, state EMPTY.
- With INPUT_HOLDER_SYNC_EN: write 0x77, empty FIFO, cipher_ready=1 -> pulse appears 2 cycles later than without the macro.
